// File: rtl/shared_mailbox_mem.sv
// Dual-port shared RAM between two Avalon-MM slaves, plus a control region with
// hardware mutexes and a doorbell mailbox (with irq) in each direction.

module shared_mailbox_port #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW:0]   address,
    input  logic          chipselect,
    input  logic          read,
    input  logic          write,
    input  logic [DW-1:0] ram_rdata,
    input  logic [DW-1:0] ctl_rdata,
    output logic [AW-1:0] word_addr,
    output logic [3:0]    offset,
    output logic          ram_wr,
    output logic          ctl_wr,
    output logic          ctl_rd,
    output logic [DW-1:0] readdata,
    output logic          readdatavalid
);
    logic          ram_rd;
    logic [DW-1:0] rdata_d, rdata_q;
    logic          rvld_d, rvld_q;

    // A write in the same cycle as a read wins; the read is dropped.
    always_comb begin
        word_addr = address[AW-1:0];
        offset    = address[3:0];
        ram_wr    = chipselect && write && !address[AW];
        ctl_wr    = chipselect && write &&  address[AW];
        ram_rd    = chipselect && read && !write && !address[AW];
        ctl_rd    = chipselect && read && !write &&  address[AW];
        rvld_d    = ram_rd || ctl_rd;
        rdata_d   = rdata_q;
        if (ram_rd)
            rdata_d = ram_rdata;
        else if (ctl_rd)
            rdata_d = ctl_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            rvld_q  <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
        end
    end

    assign readdata      = rdata_q;
    assign readdatavalid = rvld_q;
endmodule

module shared_mailbox_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_MUTEX  = 4,
    parameter     INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH:0]     address,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    irq,
    input  logic [ADDR_WIDTH:0]     address2,
    input  logic                    chipselect2,
    input  logic                    read2,
    input  logic                    write2,
    input  logic [DATA_WIDTH/8-1:0] byteenable2,
    input  logic [DATA_WIDTH-1:0]   writedata2,
    output logic [DATA_WIDTH-1:0]   readdata2,
    output logic                    readdatavalid2,
    output logic                    irq2
);
    localparam int BE    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // INIT_FILE is consumed by the vendor memory-init flow, not by this RTL.
    localparam bit unused_init = (INIT_FILE != "");

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] waddr1, waddr2;
    logic [3:0]            off1, off2;
    logic                  ram_wr1, ram_wr2, ctl_wr1, ctl_wr2, ctl_rd1, ctl_rd2;
    logic [DATA_WIDTH-1:0] ram_rdata1, ram_rdata2, ctl_rdata1, ctl_rdata2;

    logic [NUM_MUTEX-1:0]  lock_d, lock_q, own_d, own_q;
    logic [DATA_WIDTH-1:0] msg1_d, msg1_q, msg2_d, msg2_q;
    logic                  pend1_d, pend1_q, pend2_d, pend2_q;
    logic                  ovr1_d, ovr1_q, ovr2_d, ovr2_q;
    logic                  db_wr1, db_wr2, db_rd1, db_rd2, st_rd1, st_rd2;

    shared_mailbox_port #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_port1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .ram_rdata(ram_rdata1), .ctl_rdata(ctl_rdata1),
        .word_addr(waddr1), .offset(off1), .ram_wr(ram_wr1), .ctl_wr(ctl_wr1),
        .ctl_rd(ctl_rd1), .readdata(readdata), .readdatavalid(readdatavalid)
    );

    shared_mailbox_port #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_port2 (
        .clk(clk), .reset_n(reset_n), .address(address2), .chipselect(chipselect2),
        .read(read2), .write(write2), .ram_rdata(ram_rdata2), .ctl_rdata(ctl_rdata2),
        .word_addr(waddr2), .offset(off2), .ram_wr(ram_wr2), .ctl_wr(ctl_wr2),
        .ctl_rd(ctl_rd2), .readdata(readdata2), .readdatavalid(readdatavalid2)
    );

    // Reads see the pre-write word, so a cross-port read of a word being written returns old data.
    assign ram_rdata1 = mem_q[waddr1];
    assign ram_rdata2 = mem_q[waddr2];

    // Port 1 is applied last so it owns every byte lane both ports enable on a shared word.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE; b++) begin
            if (ram_wr2 && byteenable2[b])
                mem_q[waddr2][b*8 +: 8] <= writedata2[b*8 +: 8];
            if (ram_wr1 && byteenable[b])
                mem_q[waddr1][b*8 +: 8] <= writedata[b*8 +: 8];
        end
    end

    always_comb begin
        lock_d = lock_q;
        own_d  = own_q;
        for (int i = 0; i < NUM_MUTEX; i++) begin
            if (lock_q[i]) begin
                if ((ctl_wr1 && off1 == 4'(i) && !writedata[0]  && !own_q[i]) ||
                    (ctl_wr2 && off2 == 4'(i) && !writedata2[0] &&  own_q[i]))
                    lock_d[i] = 1'b0;
            end else if (ctl_wr1 && off1 == 4'(i) && writedata[0]) begin
                lock_d[i] = 1'b1;
                own_d[i]  = 1'b0;
            end else if (ctl_wr2 && off2 == 4'(i) && writedata2[0]) begin
                lock_d[i] = 1'b1;
                own_d[i]  = 1'b1;
            end
        end
    end

    // Doorbell into port q: set by the other port's write, which beats q's clearing read.
    always_comb begin
        db_wr1  = ctl_wr1 && off1 == 4'd8;
        db_wr2  = ctl_wr2 && off2 == 4'd8;
        db_rd1  = ctl_rd1 && off1 == 4'd8;
        db_rd2  = ctl_rd2 && off2 == 4'd8;
        st_rd1  = ctl_rd1 && off1 == 4'd9;
        st_rd2  = ctl_rd2 && off2 == 4'd9;
        msg1_d  = db_wr2 ? writedata2 : msg1_q;
        msg2_d  = db_wr1 ? writedata  : msg2_q;
        pend1_d = db_wr2 || (pend1_q && !db_rd1);
        pend2_d = db_wr1 || (pend2_q && !db_rd2);
        ovr1_d  = (db_wr2 && pend1_q && !db_rd1) || (ovr1_q && !st_rd1);
        ovr2_d  = (db_wr1 && pend2_q && !db_rd2) || (ovr2_q && !st_rd2);
    end

    always_comb begin
        ctl_rdata1 = '0;
        ctl_rdata2 = '0;
        for (int i = 0; i < NUM_MUTEX; i++) begin
            if (off1 == 4'(i))
                ctl_rdata1[1:0] = {own_q[i], lock_q[i]};
            if (off2 == 4'(i))
                ctl_rdata2[1:0] = {own_q[i], lock_q[i]};
        end
        if (off1 == 4'd8)
            ctl_rdata1 = msg1_q;
        else if (off1 == 4'd9)
            ctl_rdata1 = {{(DATA_WIDTH-3){1'b0}}, ovr1_q, pend2_q, pend1_q};
        if (off2 == 4'd8)
            ctl_rdata2 = msg2_q;
        else if (off2 == 4'd9)
            ctl_rdata2 = {{(DATA_WIDTH-3){1'b0}}, ovr2_q, pend1_q, pend2_q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q  <= '0;
            own_q   <= '0;
            msg1_q  <= '0;
            msg2_q  <= '0;
            pend1_q <= 1'b0;
            pend2_q <= 1'b0;
            ovr1_q  <= 1'b0;
            ovr2_q  <= 1'b0;
        end else begin
            lock_q  <= lock_d;
            own_q   <= own_d;
            msg1_q  <= msg1_d;
            msg2_q  <= msg2_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            ovr1_q  <= ovr1_d;
            ovr2_q  <= ovr2_d;
        end
    end

    assign irq  = pend1_q;
    assign irq2 = pend2_q;
endmodule

// File: tb/tb_shared_mailbox_mem.sv
// Directed scenarios plus randomized dual-port traffic against an abstract model
// of the shared RAM, mutexes and doorbells.

module tb_shared_mailbox_mem;
    localparam int NM = 4;
    localparam logic [10:0] CTL = 11'h400;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] adr [2];
    logic        cs [2], rd [2], wr [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    logic [31:0] rdata1, rdata2;
    logic        rdv1, rdv2, irq1, irq2;

    int total = 0;
    int bad = 0;

    logic [31:0] ram_m [0:1023];
    bit          lock_m [NM];
    int          own_m  [NM];
    logic [31:0] msg_m  [2];
    bit          pend_m [2];
    bit          ovr_m  [2];

    always #5 clk = ~clk;

    shared_mailbox_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .NUM_MUTEX(NM), .INIT_FILE("")) dut (
        .clk(clk), .reset_n(reset_n),
        .address(adr[0]), .chipselect(cs[0]), .read(rd[0]), .write(wr[0]),
        .byteenable(be[0]), .writedata(wd[0]), .readdata(rdata1),
        .readdatavalid(rdv1), .irq(irq1),
        .address2(adr[1]), .chipselect2(cs[1]), .read2(rd[1]), .write2(wr[1]),
        .byteenable2(be[1]), .writedata2(wd[1]), .readdata2(rdata2),
        .readdatavalid2(rdv2), .irq2(irq2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nop(input int p);
        cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0; be[p] = 4'h0; wd[p] = '0; adr[p] = '0;
    endtask

    task automatic wr_op(input int p, input logic [10:0] a, input logic [3:0] b, input logic [31:0] d);
        cs[p] = 1'b1; rd[p] = 1'b0; wr[p] = 1'b1; be[p] = b; wd[p] = d; adr[p] = a;
    endtask

    task automatic rd_op(input int p, input logic [10:0] a);
        cs[p] = 1'b1; rd[p] = 1'b1; wr[p] = 1'b0; be[p] = 4'h0; wd[p] = '0; adr[p] = a;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NM; i++) begin lock_m[i] = 0; own_m[i] = 0; end
        for (int p = 0; p < 2; p++) begin msg_m[p] = '0; pend_m[p] = 0; ovr_m[p] = 0; end
    endtask

    // One clock: predict from the current inputs, advance the model, then compare after the edge.
    task automatic step();
        logic [31:0] ed [2];
        bit ev [2], awr [2], ard [2], ctl [2];
        int off [2];
        bit op [2], oo [2];
        for (int p = 0; p < 2; p++) begin
            awr[p] = cs[p] && wr[p];
            ard[p] = cs[p] && rd[p] && !wr[p];
            ctl[p] = adr[p][10];
            off[p] = int'(adr[p][3:0]);
            ev[p]  = ard[p];
            ed[p]  = '0;
            if (ard[p]) begin
                if (!ctl[p]) ed[p] = ram_m[adr[p][9:0]];
                else if (off[p] < NM) ed[p] = {30'd0, own_m[off[p]] == 1, lock_m[off[p]]};
                else if (off[p] == 8) ed[p] = msg_m[p];
                else if (off[p] == 9) ed[p] = {29'd0, ovr_m[p], pend_m[1-p], pend_m[p]};
            end
        end
        for (int p = 1; p >= 0; p--)
            if (awr[p] && !ctl[p])
                for (int b = 0; b < 4; b++)
                    if (be[p][b]) ram_m[adr[p][9:0]][b*8 +: 8] = wd[p][b*8 +: 8];
        for (int i = 0; i < NM; i++) begin
            if (lock_m[i]) begin
                bit rel = 0;
                for (int p = 0; p < 2; p++)
                    if (awr[p] && ctl[p] && off[p] == i && !wd[p][0] && own_m[i] == p) rel = 1;
                if (rel) lock_m[i] = 0;
            end else begin
                for (int p = 0; p < 2; p++)
                    if (!lock_m[i] && awr[p] && ctl[p] && off[p] == i && wd[p][0]) begin
                        lock_m[i] = 1; own_m[i] = p;
                    end
            end
        end
        op = pend_m; oo = ovr_m;
        for (int q = 0; q < 2; q++) begin
            int  p = 1 - q;
            bit  rang = awr[p] && ctl[p] && off[p] == 8;
            bit  clr  = ard[q] && ctl[q] && off[q] == 8;
            bit  st   = ard[q] && ctl[q] && off[q] == 9;
            ovr_m[q]  = (oo[q] && !st) || (rang && op[q] && !clr);
            pend_m[q] = rang || (op[q] && !clr);
            if (rang) msg_m[q] = wd[p];
        end
        @(posedge clk); #1;
        chk("rdv1", {31'd0, rdv1}, {31'd0, ev[0]});
        chk("rdv2", {31'd0, rdv2}, {31'd0, ev[1]});
        if (ev[0]) chk("rdata1", rdata1, ed[0]);
        if (ev[1]) chk("rdata2", rdata2, ed[1]);
        chk("irq1", {31'd0, irq1}, {31'd0, pend_m[0]});
        chk("irq2", {31'd0, irq2}, {31'd0, pend_m[1]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nop(0); nop(1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdv1", {31'd0, rdv1}, 32'd0);
        chk("rst_rdv2", {31'd0, rdv2}, 32'd0);
        chk("rst_irq1", {31'd0, irq1}, 32'd0);
        chk("rst_irq2", {31'd0, irq2}, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_rdata2", rdata2, 32'd0);
        @(negedge clk) reset_n = 1'b1;

        for (int a = 0; a < 32; a++) begin wr_op(0, 11'(a), 4'hF, 32'd0); step(); end
        nop(0);

        // T1: cross-port write then read
        wr_op(0, 11'h005, 4'hF, 32'hDEADBEEF); step();
        nop(0); rd_op(1, 11'h005); step();
        chk("t1_data", rdata2, 32'hDEADBEEF);
        nop(1);

        // T2: same-word collision with overlapping lanes
        wr_op(0, 11'h010, 4'b0011, 32'h11223344);
        wr_op(1, 11'h010, 4'b0110, 32'hAABBCCDD); step();
        nop(1); rd_op(0, 11'h010); step();
        chk("t2_data", rdata1, 32'h00BB3344);

        // T3: mutex contention and ownership
        wr_op(0, CTL | 11'd2, 4'h0, 32'd1); wr_op(1, CTL | 11'd2, 4'h0, 32'd1); step();
        rd_op(0, CTL | 11'd2); rd_op(1, CTL | 11'd2); step();
        chk("t3_lock1", rdata1, 32'h1);
        chk("t3_lock2", rdata2, 32'h1);
        nop(0); wr_op(1, CTL | 11'd2, 4'h0, 32'd0); step();
        rd_op(1, CTL | 11'd2); step();
        chk("t3_foreign_unlock", rdata2, 32'h1);
        nop(1); wr_op(0, CTL | 11'd2, 4'h0, 32'd0); step();
        rd_op(0, CTL | 11'd2); step();
        chk("t3_unlock", rdata1, 32'h0);

        // T4: doorbell 1 -> 2
        wr_op(0, CTL | 11'd8, 4'h0, 32'h55); step();
        chk("t4_irq2_set", {31'd0, irq2}, 32'd1);
        nop(0); rd_op(1, CTL | 11'd8); step();
        chk("t4_msg", rdata2, 32'h55);
        chk("t4_irq2_clr", {31'd0, irq2}, 32'd0);

        // T5: overrun
        nop(1);
        wr_op(0, CTL | 11'd8, 4'h0, 32'h1); step();
        wr_op(0, CTL | 11'd8, 4'h0, 32'h2); step();
        nop(0); rd_op(1, CTL | 11'd9); step();
        chk("t5_status", rdata2, 32'h5);
        rd_op(1, CTL | 11'd8); step();
        chk("t5_msg", rdata2, 32'h2);
        rd_op(1, CTL | 11'd9); step();
        chk("t5_status_clr", rdata2, 32'h0);

        // T6: async reset with locks held, irq high and a read just returned
        wr_op(0, CTL | 11'd0, 4'h0, 32'd1); wr_op(1, CTL | 11'd3, 4'h0, 32'd1); step();
        wr_op(0, CTL | 11'd8, 4'h0, 32'h77); rd_op(1, 11'h005); step();
        chk("t6_pre_irq2", {31'd0, irq2}, 32'd1);
        rd_op(0, 11'h005); nop(1);
        @(negedge clk) reset_n = 1'b0;
        #1;
        model_reset();
        chk("t6_irq1", {31'd0, irq1}, 32'd0);
        chk("t6_irq2", {31'd0, irq2}, 32'd0);
        chk("t6_rdv1", {31'd0, rdv1}, 32'd0);
        chk("t6_rdv2", {31'd0, rdv2}, 32'd0);
        chk("t6_rdata2", rdata2, 32'd0);
        @(posedge clk); #1;
        chk("t6_lost_read", {31'd0, rdv1}, 32'd0);
        nop(0);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < NM; i++) begin
            rd_op(0, CTL | 11'(i)); step();
            chk("t6_mutex", rdata1, 32'h0);
        end
        rd_op(1, 11'h005); nop(0); step();
        chk("t6_ram_kept", rdata2, 32'hDEADBEEF);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                int kind = int'($urandom_range(0, 3));
                int sel  = int'($urandom_range(0, 6));
                cs[p] = ($urandom_range(0, 7) != 0);
                rd[p] = (kind == 1 || kind == 3);
                wr[p] = (kind >= 2);
                be[p] = 4'($urandom);
                wd[p] = $urandom;
                if ($urandom_range(0, 1) == 0)
                    adr[p] = 11'($urandom_range(0, 31));
                else case (sel)
                    4:       adr[p] = CTL | 11'd8;
                    5:       adr[p] = CTL | 11'd9;
                    6:       adr[p] = CTL | 11'($urandom_range(0, 15));
                    default: adr[p] = CTL | 11'(sel);
                endcase
            end
            if ($urandom_range(0, 3) == 0) adr[1] = adr[0];
            step();
        end
        nop(0); nop(1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
